// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared constants and helpers for the 1D convolution datapath and its
// post-processing stages.
//   BW          : activation / weight element width
//   MUL_OUT_BW  : multiplier product width
//   ADD_OUT_BW  : vector-add accumulator width
//   BIAS_BW     : per-filter bias width (signed)
//   addr_w(n)   : index width for n entries; never returns 0 so that
//                 single-entry tables still get a 1-bit index
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int unsigned BW         = 8;
  localparam int unsigned MUL_OUT_BW = 16;
  localparam int unsigned ADD_OUT_BW = 18;
  localparam int unsigned BIAS_BW    = 18;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_relu_quant_lane.sv
// -----------------------------------------------------------------------------
// relu_quant_lane
// Combinational per-element ReLU, arithmetic right shift and saturation to a
// non-negative signed OUT_BW value (0 .. 2^(OUT_BW-1)-1).
// Ports:
//   sum_i   : signed biased sum (SUM_BW bits)
//   shift_i : right-shift amount applied after ReLU
//   q_o     : quantized output element
// -----------------------------------------------------------------------------
module relu_quant_lane
  import conv_pkg::*;
#(
  parameter int unsigned SUM_BW = ADD_OUT_BW + 1,
  parameter int unsigned OUT_BW = BW
) (
  input  logic signed [SUM_BW-1:0] sum_i,
  input  logic        [4:0]        shift_i,
  output logic        [OUT_BW-1:0] q_o
);

  localparam logic [SUM_BW-1:0] QMAX = SUM_BW'((1 << (OUT_BW - 1)) - 1);

  logic [SUM_BW-1:0] relu_val;
  logic [SUM_BW-1:0] shifted;

  always_comb begin
    relu_val = sum_i[SUM_BW-1] ? '0 : $unsigned(sum_i);
    // relu_val is non-negative, so a logical shift equals the arithmetic one
    shifted  = relu_val >> shift_i;
    q_o      = (shifted > QMAX) ? QMAX[OUT_BW-1:0] : shifted[OUT_BW-1:0];
  end

endmodule

// File: rtl/bias_relu_quant.sv
// -----------------------------------------------------------------------------
// bias_relu_quant
// Post-processing stage after the 1D convolution vector-add: adds the
// per-filter bias, applies ReLU and requantizes to signed OUT_BW activations.
// Two-stage valid/ready pipeline (stage 1: bias add, stage 2: ReLU/quant).
// Ports:
//   clk_i, rst_i        : clock (rising edge), async active-high reset
//   data_i/valid_i/last_i/ready_o : accumulator input stream (filter-major)
//   data_o/valid_o/last_o/ready_i : quantized output stream
//   bias_wr_en_i/addr_i/data_i    : per-filter bias register write port
//   shift_i             : requant right shift, changed only while idle
//   frame_err_o         : sticky flag, last_i disagreed with the beat count
// -----------------------------------------------------------------------------
module bias_relu_quant #(
  parameter int unsigned FRAME_LEN   = 50,
  parameter int unsigned COLUMN_LEN  = 1,
  parameter int unsigned NUM_FILTERS = 8,
  parameter int unsigned ACC_BW      = conv_pkg::ADD_OUT_BW,
  parameter int unsigned BIAS_BW     = conv_pkg::BIAS_BW,
  parameter int unsigned OUT_BW      = conv_pkg::BW
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [COLUMN_LEN*ACC_BW-1:0]                data_i,
  input  logic                                        valid_i,
  input  logic                                        last_i,
  output logic                                        ready_o,
  output logic [COLUMN_LEN*OUT_BW-1:0]                data_o,
  output logic                                        valid_o,
  output logic                                        last_o,
  input  logic                                        ready_i,
  input  logic                                        bias_wr_en_i,
  input  logic [conv_pkg::addr_w(NUM_FILTERS)-1:0]    bias_wr_addr_i,
  input  logic [BIAS_BW-1:0]                          bias_wr_data_i,
  input  logic [4:0]                                  shift_i,
  output logic                                        frame_err_o
);

  import conv_pkg::*;

  localparam int unsigned FW     = addr_w(NUM_FILTERS);
  localparam int unsigned PW     = addr_w(FRAME_LEN);
  localparam int unsigned SUM_BW = ((ACC_BW > BIAS_BW) ? ACC_BW : BIAS_BW) + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(NUM_FILTERS - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);

  logic signed [BIAS_BW-1:0] bias_q [NUM_FILTERS];

  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [PW-1:0] pos_cnt_q, pos_cnt_d;
  logic          frame_err_q, frame_err_d;

  logic                     s1_valid_q, s1_last_q;
  logic signed [SUM_BW-1:0] s1_sum_q [COLUMN_LEN];
  logic signed [SUM_BW-1:0] s1_sum_d [COLUMN_LEN];

  logic                         s2_valid_q, s2_last_q;
  logic [COLUMN_LEN*OUT_BW-1:0] s2_data_q, lane_q;

  logic s2_adv, s1_adv, accept, terminal;
  logic signed [BIAS_BW-1:0] bias_sel;

  assign s2_adv   = !s2_valid_q || ready_i;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign accept   = valid_i && s1_adv;
  assign terminal = (filt_cnt_q == FILT_LAST) && (pos_cnt_q == POS_LAST);
  assign bias_sel = bias_q[filt_cnt_q];

  always_comb begin
    for (int unsigned k = 0; k < COLUMN_LEN; k++) begin
      s1_sum_d[k] = SUM_BW'($signed(data_i[k*ACC_BW +: ACC_BW])) + SUM_BW'(bias_sel);
    end
  end

  always_comb begin
    filt_cnt_d  = filt_cnt_q;
    pos_cnt_d   = pos_cnt_q;
    frame_err_d = frame_err_q;
    if (accept) begin
      if (last_i != terminal) frame_err_d = 1'b1;
      // last_i always resynchronises, and a missed last still wraps
      if (last_i || terminal) begin
        filt_cnt_d = '0;
        pos_cnt_d  = '0;
      end else if (pos_cnt_q == POS_LAST) begin
        pos_cnt_d  = '0;
        filt_cnt_d = filt_cnt_q + FW'(1);
      end else begin
        pos_cnt_d  = pos_cnt_q + PW'(1);
      end
    end
  end

  for (genvar k = 0; k < COLUMN_LEN; k++) begin : g_lane
    relu_quant_lane #(
      .SUM_BW (SUM_BW),
      .OUT_BW (OUT_BW)
    ) u_lane (
      .sum_i   (s1_sum_q[k]),
      .shift_i (shift_i),
      .q_o     (lane_q[k*OUT_BW +: OUT_BW])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_FILTERS; i++) bias_q[i] <= '0;
      for (int unsigned k = 0; k < COLUMN_LEN; k++) s1_sum_q[k] <= '0;
      filt_cnt_q  <= '0;
      pos_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_data_q   <= '0;
    end else begin
      // the stage-1 read of bias_sel sees the pre-write value on a shared edge
      if (bias_wr_en_i && (32'(bias_wr_addr_i) < NUM_FILTERS)) begin
        bias_q[bias_wr_addr_i] <= bias_wr_data_i;
      end
      filt_cnt_q  <= filt_cnt_d;
      pos_cnt_q   <= pos_cnt_d;
      frame_err_q <= frame_err_d;
      if (s1_adv) begin
        s1_valid_q <= valid_i;
        if (valid_i) begin
          s1_last_q <= last_i;
          for (int unsigned k = 0; k < COLUMN_LEN; k++) s1_sum_q[k] <= s1_sum_d[k];
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_last_q <= s1_last_q;
          s2_data_q <= lane_q;
        end
      end
    end
  end

  assign ready_o     = s1_adv;
  assign valid_o     = s2_valid_q;
  assign last_o      = s2_last_q;
  assign data_o      = s2_data_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_bias_relu_quant.sv
// -----------------------------------------------------------------------------
// tb_bias_relu_quant
// Directed bench for bias_relu_quant with FRAME_LEN=4, NUM_FILTERS=3 (so the
// out-of-range bias address 3 exists on the 2-bit write port).
// -----------------------------------------------------------------------------
module tb_bias_relu_quant;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [17:0] data_i;
  logic        valid_i, last_i, ready_o;
  logic [7:0]  data_o;
  logic        valid_o, last_o, ready_i;
  logic        bias_wr_en_i;
  logic [1:0]  bias_wr_addr_i;
  logic [17:0] bias_wr_data_i;
  logic [4:0]  shift_i;
  logic        frame_err_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic       tx_done;

  bias_relu_quant #(
    .FRAME_LEN   (4),
    .COLUMN_LEN  (1),
    .NUM_FILTERS (3),
    .ACC_BW      (18),
    .BIAS_BW     (18),
    .OUT_BW      (8)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .last_i         (last_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .last_o         (last_o),
    .ready_i        (ready_i),
    .bias_wr_en_i   (bias_wr_en_i),
    .bias_wr_addr_i (bias_wr_addr_i),
    .bias_wr_data_i (bias_wr_data_i),
    .shift_i        (shift_i),
    .frame_err_o    (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  // inputs change 1 time unit after posedge, so negedge sees next-edge values
  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) got_q.push_back({last_o, data_o});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic send(input logic [17:0] d, input logic l);
    int unsigned n;
    data_i  = d;
    last_i  = l;
    valid_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      n_errors++;
      $display("FAIL send_timeout: ready_o got 0 expected 1");
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic wr_bias(input logic [1:0] a, input logic [17:0] v);
    bias_wr_en_i   = 1'b1;
    bias_wr_addr_i = a;
    bias_wr_data_i = v;
    @(posedge clk_i);
    #1;
    bias_wr_en_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic drain_and_compare(input string tag);
    repeat (6) @(posedge clk_i);
    #1;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_tx_done(input string tag);
    int unsigned n;
    n = 0;
    while (!tx_done && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    check({tag, "_tx_done"}, tx_done, 1);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = '0; ready_i = 1'b1;
    bias_wr_en_i = 1'b0; bias_wr_addr_i = '0; bias_wr_data_i = '0; shift_i = '0;
    tx_done = 1'b0;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_last", last_o, 0);
    check("rst_data", data_o, 0);
    check("rst_err", frame_err_o, 0);
    check("rst_ready", ready_o, 1);
    rst_i = 1'b0;

    // zero bias, no shift: pass, ReLU clamp, saturation; latency 2
    send(18'd5, 1'b0);
    check("lat_s1_only", valid_o, 0);
    @(posedge clk_i);
    #1;
    check("lat_valid", valid_o, 1);
    check("lat_data", data_o, 5);
    expect_out(8'd5, 1'b0);
    send(-18'sd3, 1'b0);      expect_out(8'd0, 1'b0);
    send(18'd200, 1'b0);      expect_out(8'd127, 1'b0);
    send(18'h1FFFF, 1'b0);    expect_out(8'd127, 1'b0);
    send(18'h20000, 1'b0);    expect_out(8'd0, 1'b0);
    send(18'd127, 1'b0);      expect_out(8'd127, 1'b0);
    send(18'd128, 1'b0);      expect_out(8'd127, 1'b0);
    drain_and_compare("basic");

    // per-filter bias with shift 2 over a full set and into the next one
    do_reset();
    shift_i = 5'd2;
    wr_bias(2'd0, 18'd40);
    wr_bias(2'd1, -18'sd20);
    wr_bias(2'd2, -18'sd100);
    wr_bias(2'd3, 18'h1FFFF);  // no such filter; must not disturb 0..2
    send(18'd0, 1'b0);        expect_out(8'd10, 1'b0);
    send(18'd4, 1'b0);        expect_out(8'd11, 1'b0);
    send(-18'sd40, 1'b0);     expect_out(8'd0, 1'b0);
    send(-18'sd41, 1'b0);     expect_out(8'd0, 1'b0);
    send(18'd100, 1'b0);      expect_out(8'd20, 1'b0);
    send(18'd19, 1'b0);       expect_out(8'd0, 1'b0);
    send(18'd20, 1'b0);       expect_out(8'd0, 1'b0);
    send(-18'sd500, 1'b0);    expect_out(8'd0, 1'b0);
    send(18'd500, 1'b0);      expect_out(8'd100, 1'b0);
    send(18'd50, 1'b0);       expect_out(8'd0, 1'b0);
    send(18'd1000, 1'b0);     expect_out(8'd127, 1'b0);
    send(18'd104, 1'b1);      expect_out(8'd1, 1'b1);
    check("set_err_clean", frame_err_o, 0);
    send(18'd100, 1'b0);      expect_out(8'd35, 1'b0);
    send(18'd0, 1'b0);        expect_out(8'd10, 1'b0);
    drain_and_compare("bias");
    check("set2_err_clean", frame_err_o, 0);

    // backpressure: two beats buffered, output held stable
    do_reset();
    shift_i = 5'd0;
    ready_i = 1'b0;
    tx_done = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(18'(i), 1'b0);
        tx_done = 1'b1;
      end
    join_none
    @(posedge clk_i);
    @(posedge clk_i);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check($sformatf("stall_ready_%0d", c), ready_o, 0);
      check($sformatf("stall_valid_%0d", c), valid_o, 1);
      check($sformatf("stall_data_%0d", c), data_o, 1);
    end
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    for (int i = 1; i <= 6; i++) expect_out(8'(i), 1'b0);
    wait_tx_done("stall");
    drain_and_compare("stall");

    // early last: sticky error, counters restart; missed last still wraps
    do_reset();
    wr_bias(2'd0, 18'd7);
    wr_bias(2'd1, 18'd50);
    for (int i = 1; i <= 4; i++) begin
      send(18'(i), 1'b0);
      expect_out(8'(i + 7), 1'b0);
    end
    send(18'd5, 1'b0);        expect_out(8'd55, 1'b0);
    check("err_before", frame_err_o, 0);
    send(18'd6, 1'b1);        expect_out(8'd56, 1'b1);
    check("err_set", frame_err_o, 1);
    send(18'd10, 1'b0);       expect_out(8'd17, 1'b0);
    for (int i = 0; i < 11; i++) begin
      send(18'd0, 1'b0);
      expect_out((i < 3) ? 8'd7 : ((i < 7) ? 8'd50 : 8'd0), 1'b0);
    end
    send(18'd0, 1'b0);        expect_out(8'd7, 1'b0);
    drain_and_compare("err");
    check("err_sticky", frame_err_o, 1);

    // bias write on the same edge as a beat on that filter
    do_reset();
    wr_bias(2'd0, 18'd10);
    bias_wr_en_i   = 1'b1;
    bias_wr_addr_i = 2'd0;
    bias_wr_data_i = 18'd30;
    send(18'd0, 1'b0);        expect_out(8'd10, 1'b0);
    bias_wr_en_i = 1'b0;
    send(18'd0, 1'b0);        expect_out(8'd30, 1'b0);
    drain_and_compare("same_edge");

    // reset in the middle of a stall discards both stages
    ready_i = 1'b0;
    tx_done = 1'b0;
    fork
      begin
        send(18'd5, 1'b1);
        send(18'd6, 1'b0);
        tx_done = 1'b1;
      end
    join_none
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check("prerst_valid", valid_o, 1);
    check("prerst_err", frame_err_o, 1);
    check("prerst_tx_done", tx_done, 1);
    rst_i = 1'b1;
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_err", frame_err_o, 0);
    check("midrst_data", data_o, 0);
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    got_q.delete();
    exp_q.delete();
    send(18'd0, 1'b0);        expect_out(8'd0, 1'b0);
    drain_and_compare("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bias_relu_quant.md
Name: bias_relu_quant

Overview:
- Post-processing stage directly downstream of the 1D convolution datapath.
- Consumes the vector-add accumulator stream (one COLUMN_LEN vector of 18-bit signed sums per beat) and adds the per-filter bias.
- Applies ReLU, then requantizes to 8-bit signed activations for the next layer.
- Tracks filter/position counters against last_i and exposes a sticky framing error.

Parameters:
- FRAME_LEN, 50: frame positions per filter.
- COLUMN_LEN, 1: vector elements per beat.
- NUM_FILTERS, 8: filters per frame set.
- ACC_BW, 18: input accumulator width per element.
- BIAS_BW, 18: bias width (signed).
- OUT_BW, 8: output element width (signed).

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset; asynchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
- data_i, in, COLUMN_LEN*ACC_BW: signed accumulator vector; element k at bits [k*ACC_BW +: ACC_BW].
- valid_i, in, 1: input beat valid.
- last_i, in, 1: final beat of the frame set.
- ready_o, out, 1: stage can accept a beat.
- data_o, out, COLUMN_LEN*OUT_BW: signed quantized vector.
- valid_o, out, 1: output valid.
- last_o, out, 1: last flag aligned with data_o.
- ready_i, in, 1: downstream accept.
- bias_wr_en_i, in, 1: bias register write strobe.
- bias_wr_addr_i, in, $clog2(NUM_FILTERS): filter index to write.
- bias_wr_data_i, in, BIAS_BW: signed bias value.
- shift_i, in, 5: requant right-shift amount; quasi-static, only changed while idle.
- frame_err_o, out, 1: sticky framing error.

Behaviour:
- Reset (async, on rst_i high):
  - valid_o=0, last_o=0, data_o=0, frame_err_o=0.
  - Both pipe stages empty; filter and position counters = 0.
  - All biases = 0.
- Input order is filter-major: FRAME_LEN beats for filter 0, then filter 1, and so on; NUM_FILTERS*FRAME_LEN beats per set.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Once valid_o is high, data_o/last_o hold stable until ready_i.
- Pipeline (2 stages, latency 2 cycles with no stall):
  - s2_adv = !s2_valid || ready_i.
  - s1_adv = !s1_valid || s2_adv.
  - ready_o = s1_adv. This path is combinational from ready_i; it is allowed.
  - Stage 1: per element, sum = sext(data) + sext(bias[filt_cnt]), computed at ACC_BW+1 = 19 bits, so no overflow. Captures last_i.
  - Stage 2: per element, r = (sum<0) ? 0 : sum; q = r >> shift_i; out = (q > 127) ? 127 : q[7:0]. Outputs are always in 0..127.
- Counters:
  - Advance on each accepted input beat.
  - pos_cnt wraps at FRAME_LEN-1 and then increments filt_cnt.
  - Terminal beat: filt_cnt==NUM_FILTERS-1 && pos_cnt==FRAME_LEN-1.
  - Accepted beat with last_i=1: both counters clear to 0.
  - frame_err_o sets if last_i=1 on a non-terminal beat, or last_i=0 on a terminal beat. In the second case counters still wrap to 0.
  - frame_err_o clears only on reset; data is still passed through after an error.
- Bias write:
  - Registered. Takes effect for beats accepted on later edges.
  - A write to the same address as the beat accepted on the same edge: that beat uses the old value.
  - Out-of-range address (non-power-of-2 NUM_FILTERS) is ignored.
- Reset mid-frame discards both stage contents; no partial output is emitted.
- valid_i held with ready_o=0: nothing is captured, counters hold.

Decomposition:
- Shared package (conv_pkg):
  - Constants BW=8, MUL_OUT_BW=16, ADD_OUT_BW=18, BIAS_BW=18.
  - Function clog2-safe address width.
- Sub-module: relu_quant_lane. Per-element stage-2 combinational ReLU/shift/saturate, instantiated COLUMN_LEN times via generate.

Test Plan:
- Bias=0, shift=0, single beat data=5 -> data_o=5 two cycles later. Repeat with data=-3 -> 0. Repeat with data=200 -> 127.
- bias[2]=-100, shift=2, beats for filter 2 with data=500 -> (400>>2)=100. With data=50 -> 0.
- Full set FRAME_LEN=4, NUM_FILTERS=2: 8 beats, last_i on the 8th -> last_o on the 8th output, frame_err_o stays 0. Then a second set -> counters restart and bias[0] is applied again.
- ready_i held low 5 cycles with valid_i continuously high -> ready_o drops after 2 beats buffered, data_o stable. On release, all beats delivered in order with no loss or duplication.
- last_i on beat 3 of 8 -> frame_err_o=1 from the next cycle, and it persists. Counters restart so beat 4 uses bias[0].
- Bias write to filter 0 on the same edge as a filter-0 beat is accepted -> that beat uses the old bias and the next beat uses the new one. Assert rst_i mid-stall -> valid_o=0 immediately and frame_err_o=0.
